mmio_interconnect: RTL
======================

# mmio_interconnect

Parametrised memory-mapped interconnect between the cpu data port and NSLV peripheral slaves. It is the next-generation replacement for the fixed-slave data-side arbiter. It decodes a slave index from the data address and runs a request/ready handshake so slaves may insert wait states. It bounds every access with a timeout and reports unmapped or timed-out accesses through an error pulse and a sticky error/address latch.

## Interface
- NSLV, 6: number of slaves, 2..16; SELW = ceil(log2(NSLV)).
- SEL_LSB, 24: lowest address bit of the slave-index field daddr[SEL_LSB+SELW-1:SEL_LSB].
- DW, 32: data width.
- TIMEOUT, 255: maximum wait cycles per access, 1..65535.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- cpu_req  in  1  cpu access request, sampled in IDLE only.
- drw  in  1  1 = write, 0 = read.
- daddr  in  32  byte address.
- dout  in  DW  cpu write data.
- din  out  DW  read data to cpu, registered.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  one-cycle error pulse, coincident with cpu_ack.
- err_clr  in  1  clears bus_err and err_addr.
- bus_err  out  1  sticky: an error has occurred since the last clear.
- err_addr  out  32  daddr of the first error since the last clear.
- s_req  out  NSLV  one-hot slave request, held until ready or abort.
- s_we  out  1  write enable to slaves.
- s_addr  out  32  daddr[SEL_LSB-1:0], zero-extended.
- s_wdata  out  DW  latched write data.
- s_rdata  in  NSLV*DW  slave k read data at [k*DW +: DW].
- s_ready  in  NSLV  slave k completes its access when s_ready[k] is high while s_req[k] is high.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE with cpu_req=1:
  - Latch idx, drw, s_addr, s_wdata.
  - If idx < NSLV: go to WAIT, set s_req[idx]=1 and s_we=drw, clear the wait counter.
  - If idx >= NSLV (unmapped): go to DONE with error; no s_req is asserted.
- WAIT:
  - If s_ready[idx]=1: for a read, capture s_rdata[idx] into din; for a write, din is unchanged. Clear s_req and go to DONE without error.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: clear s_req, set din=0, go to DONE with error.
- s_ready on non-selected slaves is ignored.
- DONE: cpu_ack=1 for one cycle, cpu_err=1 if the access erred, then return to IDLE.
- cpu_req is ignored in WAIT and DONE. A request held high through DONE is accepted again in the following IDLE cycle.
- Error latch:
  - On an error ack, set bus_err. If bus_err was 0, load err_addr with the faulting daddr; later errors keep the first address.
  - err_clr=1 clears both latches. If err_clr and an error ack occur in the same cycle, the error wins: bus_err=1 and err_addr is loaded with the new daddr.
- Reset (rst=0, any state, including mid-access):
  - state=IDLE, s_req=0, s_we=0, s_addr=0, s_wdata=0, din=0, cpu_ack=0, cpu_err=0, bus_err=0, err_addr=0.
  - An interrupted access produces no ack.

## Timing
- Request sampled at edge N → s_req valid from N+1.
- s_ready high during cycle M → cpu_ack and din valid during M+1; s_req low during M+1.
- Minimum latency: ready in the first WAIT cycle → ack 2 cycles after cpu_req is sampled.
- Back-to-back throughput: one access per 3 cycles minimum.
- Unmapped access: ack with err 1 cycle after the request is sampled.
- Timeout: s_req is high for exactly TIMEOUT cycles, then ack with err in the next cycle.
- s_addr, s_we and s_wdata are stable for the whole WAIT period.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs → every output is 0 and no s_req bit is set.
- Zero-wait read: daddr=0x0200_0010, slave 2 ready immediately with data 0xCAFE_F00D → s_req=6'b000100 for 1 cycle, s_addr=0x10; ack with din=0xCAFEF00D 2 cycles after request; cpu_err=0.
- Wait-state write: daddr=0x0500_0004, dout=0x1234_5678, slave 5 ready after 7 cycles → s_we=1 and s_wdata stable for 7 cycles; ack on cycle 9; din unchanged.
- Unmapped access: daddr=0x0700_0000 with NSLV=6 → no s_req; cpu_ack=cpu_err=1 next cycle; bus_err=1, err_addr=0x0700_0000. A second error at 0x0600_0000 leaves err_addr=0x0700_0000.
- Timeout and clear: TIMEOUT=4, slave 0 never ready → s_req[0] high 4 cycles; ack with err and din=0. err_clr asserted alone clears bus_err; err_clr in the same cycle as a new error ack leaves bus_err=1.
- Reset mid-WAIT: slave 3 access, rst=0 on the 3rd wait cycle → s_req=0 next edge; no cpu_ack during or after reset until a new request.

Source files
------------

// File: rtl/mmio_interconnect_if.sv
// mmio_interconnect_if: bundles the cpu data-port signals and the peripheral
// slave signals of the memory-mapped interconnect.
//   modport slave  - the interconnect's view (cpu inputs/slave returns in,
//                    completion/error/slave strobes out)
//   modport master - the environment's view (cpu plus peripherals)
// Parameters: NSLV number of slaves, DW data width.
interface mmio_interconnect_if #(
  parameter int NSLV = 6,
  parameter int DW   = 32
);
  // cpu side
  logic                 cpu_req;
  logic                 drw;
  logic [31:0]          daddr;
  logic [DW-1:0]        dout;
  logic [DW-1:0]        din;
  logic                 cpu_ack;
  logic                 cpu_err;
  // error latch
  logic                 err_clr;
  logic                 bus_err;
  logic [31:0]          err_addr;
  // slave side
  logic [NSLV-1:0]      s_req;
  logic                 s_we;
  logic [31:0]          s_addr;
  logic [DW-1:0]        s_wdata;
  logic [NSLV*DW-1:0]   s_rdata;
  logic [NSLV-1:0]      s_ready;

  modport slave (
    input  cpu_req, drw, daddr, dout, err_clr, s_rdata, s_ready,
    output din, cpu_ack, cpu_err, bus_err, err_addr, s_req, s_we, s_addr, s_wdata
  );

  modport master (
    output cpu_req, drw, daddr, dout, err_clr, s_rdata, s_ready,
    input  din, cpu_ack, cpu_err, bus_err, err_addr, s_req, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mmio_interconnect.sv
// mmio_interconnect: decodes a slave index from daddr[SEL_LSB +: SELW] and runs
// a request/ready handshake with one of NSLV slaves. Every access is bounded
// by TIMEOUT wait cycles; unmapped or timed-out accesses complete with an
// error pulse and update a sticky bus_err / err_addr latch.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - mmio_interconnect_if.slave: cpu_req/drw/daddr/dout/din/cpu_ack/
//          cpu_err, err_clr/bus_err/err_addr, s_req/s_we/s_addr/s_wdata/
//          s_rdata/s_ready
module mmio_interconnect #(
  parameter int NSLV    = 6,
  parameter int SEL_LSB = 24,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mmio_interconnect_if.slave  bus
);

  localparam int SELW = $clog2(NSLV);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          r_state, w_next;
  logic [SELW-1:0] r_idx;
  logic [SELW-1:0] w_idx;
  logic            w_mapped;
  logic            r_we;
  logic            r_err;
  logic            r_bus_err;
  logic [31:0]     r_daddr;
  logic [31:0]     r_saddr;
  logic [31:0]     r_err_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_din;
  logic [DW-1:0]   w_rdata;
  logic            w_ready;
  logic            w_last;
  logic            w_err_ack;
  logic [15:0]     r_cnt;

  assign w_idx     = bus.daddr[SEL_LSB +: SELW];
  assign w_mapped  = (32'(w_idx) < 32'(NSLV));
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_err_ack = (r_state == DONE) && r_err;

  // Select the addressed slave's ready/data; other slaves are ignored.
  always_comb begin
    w_ready = 1'b0;
    w_rdata = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      if (r_idx == SELW'(k)) begin
        w_ready = bus.s_ready[k];
        w_rdata = bus.s_rdata[k*DW +: DW];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (bus.cpu_req) w_next = w_mapped ? WAIT : DONE;
      WAIT: if (w_ready || w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    for (int unsigned k = 0; k < NSLV; k++)
      bus.s_req[k] = (r_state == WAIT) && (r_idx == SELW'(k));
    bus.cpu_ack  = (r_state == DONE);
    bus.cpu_err  = w_err_ack;
    bus.s_we     = r_we;
    bus.s_addr   = r_saddr;
    bus.s_wdata  = r_wdata;
    bus.din      = r_din;
    bus.bus_err  = r_bus_err;
    bus.err_addr = r_err_addr;
  end

  // Access datapath and sticky error latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_daddr    <= '0;
      r_saddr    <= '0;
      r_wdata    <= '0;
      r_din      <= '0;
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.cpu_req) begin
          r_idx   <= w_idx;
          r_we    <= bus.drw;
          r_saddr <= 32'(bus.daddr[SEL_LSB-1:0]);
          r_wdata <= bus.dout;
          r_daddr <= bus.daddr;
          r_cnt   <= '0;
          r_err   <= !w_mapped;
        end
        WAIT: begin
          if (w_ready) begin
            if (!r_we) r_din <= w_rdata;
            r_err <= 1'b0;
          end else if (w_last) begin
            r_din <= '0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase

      // A new error beats a simultaneous clear and then reloads the address.
      if (w_err_ack) begin
        r_bus_err <= 1'b1;
        if (!r_bus_err || bus.err_clr) r_err_addr <= r_daddr;
      end else if (bus.err_clr) begin
        r_bus_err  <= 1'b0;
        r_err_addr <= '0;
      end
    end
  end

endmodule
